// File: rtl/ahb_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// ahb_resp_pkg
// Shared types and encodings for the AHB-lite memory responder.
//   state_t      : responder FSM states (IDLE, DATA, WAIT, ERR1, ERR2)
//   HTRANS_*     : one-bit transfer-valid encoding used on i_htrans
//   HRESP_*      : one-bit response encoding used on o_hresp
// ----------------------------------------------------------------------------
package ahb_resp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    WAIT = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_t;

  localparam logic HTRANS_IDLE   = 1'b0;
  localparam logic HTRANS_ACTIVE = 1'b1;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_mem_responder_if.sv
// ----------------------------------------------------------------------------
// ahb_mem_responder_if
// AHB-lite bus bundle between a master and the memory responder.
//   i_haddr  : transfer address (address phase)
//   i_hwrite : 1 = write, 0 = read (address phase)
//   i_htrans : 1 = transfer valid, 0 = idle
//   i_hwdata : write data (data phase)
//   o_hrdata : read data, valid when o_hready=1 in a read data phase
//   o_hready : slave ready / data phase complete
//   o_hresp  : 0 = OKAY, 1 = ERROR
//
// Handshake: an address phase is taken on a rising edge where i_htrans=1 and
// o_hready=1. The master must hold the address phase signals stable while
// o_hready=0. The data phase of a transfer ends on the first rising edge
// with o_hready=1; i_hwdata must be held for the whole data phase and
// o_hrdata/o_hresp are only meaningful in that final cycle (o_hresp is also
// high in the first, non-ready cycle of an ERROR response).
// ----------------------------------------------------------------------------
interface ahb_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] i_haddr;
  logic                  i_hwrite;
  logic                  i_htrans;
  logic [DATA_WIDTH-1:0] i_hwdata;
  logic [DATA_WIDTH-1:0] o_hrdata;
  logic                  o_hready;
  logic                  o_hresp;

  modport master (
    output i_haddr, i_hwrite, i_htrans, i_hwdata,
    input  o_hrdata, o_hready, o_hresp
  );

  modport slave (
    input  i_haddr, i_hwrite, i_htrans, i_hwdata,
    output o_hrdata, o_hready, o_hresp
  );

endinterface

// File: rtl/ahb_mem_responder_sram_array.sv
// ----------------------------------------------------------------------------
// ahb_sram_array
// Synchronous word array with one write port and one registered read port.
// Contents are not reset; only the read data register is.
//   clk, rst : clock, asynchronous active-high reset (read register only)
//   wr_en    : write mem[wr_idx] <= wr_data on the rising edge
//   rd_en    : capture mem[rd_idx] into rd_data on the rising edge
//   rd_data  : registered read data, holds its value while rd_en=0
// ----------------------------------------------------------------------------
module ahb_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Same-edge read of a location being written returns the old word; the
  // parent covers that case with its own forwarding path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/ahb_mem_responder.sv
// ----------------------------------------------------------------------------
// ahb_mem_responder
// AHB-lite slave memory. Word-addressed array covering
// BASE_ADDR .. BASE_ADDR+MEM_DEPTH-1; anything else gets a two-cycle ERROR.
//
// Build option: define AHB_RESP_WAIT_STATES_EN to insert WAIT_CYCLES wait
// states before every in-range data phase. Without it the WAIT state and its
// counter are not built and all OKAY transfers are zero-wait.
//
// Ports:
//   clk          : clock
//   rst          : asynchronous active-high reset
//   bus          : AHB-lite slave side (ahb_mem_responder_if.slave)
//   o_err_sticky : set by any ERROR response, cleared only by reset
//   dbg_state    : current FSM state, for observation only
// ----------------------------------------------------------------------------
module ahb_mem_responder
  import ahb_resp_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  ahb_mem_responder_if.slave bus,
  output logic               o_err_sticky,
  output state_t             dbg_state
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

`ifdef AHB_RESP_WAIT_STATES_EN
  localparam bit WAITS_EN = 1'b1;
`else
  localparam bit WAITS_EN = 1'b0;
`endif

  state_t                state;
  state_t                nxt;
  logic                  hready_q;
  logic                  hresp_q;
  logic                  sticky_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  fwd_sel_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IDX_W-1:0]      req_idx;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Address decode. The offset is compared one bit wider so a MEM_DEPTH equal
  // to 2**ADDR_WIDTH cannot overflow the comparison.
  assign offset   = bus.i_haddr - BASE_ADDR;
  assign in_range = (bus.i_haddr >= BASE_ADDR) && ({1'b0, offset} < DEPTH_EXT);
  assign req_idx  = offset[IDX_W-1:0];

  // hready_q is the registered o_hready, so accept follows the bus rule.
  assign accept = (bus.i_htrans == HTRANS_ACTIVE) && hready_q;

  // A write commits in the single ready cycle of its data phase.
  assign wr_en = (state == DATA) && write_q;

  // Read data is captured at address acceptance and then held through any
  // wait states, so o_hrdata only moves when a new in-range read is taken.
  assign rd_en = accept && !bus.i_hwrite && in_range;

  function automatic state_t accept_target(input logic rng);
    if (!rng) begin
      return ERR1;
    end
    if (WAITS_EN && (WAIT_CYCLES > 0)) begin
      return WAIT;
    end
    return DATA;
  endfunction

`ifdef AHB_RESP_WAIT_STATES_EN
  localparam int WC_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [WC_W-1:0] wait_cnt;
  logic            wait_done;

  assign wait_done = (wait_cnt == '0);

  // Loads WAIT_CYCLES-1 on entry so WAIT lasts exactly WAIT_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state != WAIT) && (nxt == WAIT)) begin
      wait_cnt <= WC_W'(WAIT_CYCLES - 1);
    end else if ((state == WAIT) && !wait_done) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end
`else
  logic wait_done;
  assign wait_done = 1'b1;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DATA, ERR2: nxt = accept ? accept_target(in_range) : IDLE;
      WAIT:             nxt = wait_done ? DATA : WAIT;
      ERR1:             nxt = ERR2;
      default:          nxt = IDLE;
    endcase
  end

  // FSM with outputs registered from the next state, so o_hready/o_hresp
  // are glitch-free and aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
      sticky_q   <= 1'b0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      state    <= nxt;
      hready_q <= (nxt == IDLE) || (nxt == DATA) || (nxt == ERR2);
      hresp_q  <= ((nxt == ERR1) || (nxt == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      if (state == ERR1) begin
        sticky_q <= 1'b1;
      end
      if (accept) begin
        idx_q   <= req_idx;
        write_q <= bus.i_hwrite;
      end
      // A read taken on the edge that commits a write to the same word must
      // see the new data; the array alone would return the stale word.
      if (rd_en) begin
        fwd_sel_q  <= wr_en && (idx_q == req_idx);
        fwd_data_q <= bus.i_hwdata;
      end
    end
  end

  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (bus.i_hwdata),
    .rd_en   (rd_en),
    .rd_idx  (req_idx),
    .rd_data (arr_rdata)
  );

  assign bus.o_hrdata = fwd_sel_q ? fwd_data_q : arr_rdata;
  assign bus.o_hready = hready_q;
  assign bus.o_hresp  = hresp_q;
  assign o_err_sticky = sticky_q;
  assign dbg_state    = state;

endmodule
